// File: rtl/gci_std_kmc_ps2_rx.sv
// PS/2 receive deserializer: falling-edge framing of 11-bit frames into a one-entry valid/ready buffer.
// Optional clock glitch filter enabled by defining GCI_STD_KMC_PS2_RX_FILTER_EN.
module gci_std_kmc_ps2_rx #(
  parameter int P_TIMEOUT = 100000,
  parameter int P_FILTER  = 8
) (
  input  logic       iCLOCK,
  input  logic       iRESET,
  input  logic       iRESET_SYNC,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DATA,
  output logic       oDATA_VALID,
  output logic [7:0] oDATA,
  input  logic       iDATA_READY,
  output logic       oERR_PARITY,
  output logic       oERR_FRAME,
  output logic       oERR_TIMEOUT,
  output logic       oOVERRUN
);
  localparam int TW = $clog2(P_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(P_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state_q;
  logic [7:0]    shreg_q;
  logic [2:0]    bcnt_q;
  logic          par_ok_q;
  logic [TW-1:0] tmo_q;
  logic          prev_clk_q;
  logic [7:0]    data_q;
  logic          valid_q, perr_q, ferr_q, terr_q, ovr_q;
  logic          clk_s, fall;

`ifdef GCI_STD_KMC_PS2_RX_FILTER_EN
  localparam int FW = $clog2(P_FILTER + 1);
  logic          filt_q;
  logic [FW-1:0] run_q;

  // filt_q follows iPS2_CLK only after P_FILTER consecutive differing samples
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      filt_q <= 1'b1;
      run_q  <= '0;
    end else if (iRESET_SYNC) begin
      filt_q <= 1'b1;
      run_q  <= '0;
    end else if (iPS2_CLK == filt_q) begin
      run_q  <= '0;
    end else if (run_q == FW'(P_FILTER - 1)) begin
      filt_q <= iPS2_CLK;
      run_q  <= '0;
    end else begin
      run_q  <= run_q + 1'b1;
    end
  end
  assign clk_s = filt_q;
`else
  assign clk_s = iPS2_CLK;
`endif

  assign fall = prev_clk_q & ~clk_s;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= IDLE; shreg_q <= '0; bcnt_q <= '0; par_ok_q <= 1'b0; tmo_q <= '0;
      prev_clk_q <= 1'b1; data_q <= '0; valid_q <= 1'b0;
      perr_q <= 1'b0; ferr_q <= 1'b0; terr_q <= 1'b0; ovr_q <= 1'b0;
    end else if (iRESET_SYNC) begin
      state_q <= IDLE; shreg_q <= '0; bcnt_q <= '0; par_ok_q <= 1'b0; tmo_q <= '0;
      prev_clk_q <= 1'b1; data_q <= '0; valid_q <= 1'b0;
      perr_q <= 1'b0; ferr_q <= 1'b0; terr_q <= 1'b0; ovr_q <= 1'b0;
    end else begin
      prev_clk_q <= clk_s;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      terr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (valid_q && iDATA_READY) valid_q <= 1'b0;

      // a fall in the same cycle as expiry wins: the frame keeps going
      if (state_q == IDLE || fall) begin
        tmo_q <= '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_q   <= '0;
        terr_q  <= 1'b1;
        state_q <= IDLE;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (fall) begin
        case (state_q)
          IDLE: if (!iPS2_DATA) begin
            state_q <= DATA;
            bcnt_q  <= '0;
          end
          DATA: begin
            shreg_q <= {iPS2_DATA, shreg_q[7:1]};
            bcnt_q  <= bcnt_q + 1'b1;
            if (bcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_ok_q <= ^shreg_q ^ iPS2_DATA;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!iPS2_DATA)     ferr_q <= 1'b1;
            else if (!par_ok_q) perr_q <= 1'b1;
            else if (!valid_q || iDATA_READY) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign oDATA_VALID  = valid_q;
  assign oDATA        = data_q;
  assign oERR_PARITY  = perr_q;
  assign oERR_FRAME   = ferr_q;
  assign oERR_TIMEOUT = terr_q;
  assign oOVERRUN     = ovr_q;
endmodule

// File: tb/tb_gci_std_kmc_ps2_rx.sv
// Directed bench for gci_std_kmc_ps2_rx: good/bad frames, timeout, overrun, resets, clock glitch.
module tb_gci_std_kmc_ps2_rx;
  localparam int TMO = 64;
  localparam int FLT = 8;

  logic       iCLOCK = 1'b0, iRESET = 1'b1, iRESET_SYNC = 1'b0;
  logic       iPS2_CLK = 1'b1, iPS2_DATA = 1'b1, iDATA_READY = 1'b0;
  logic       oDATA_VALID, oERR_PARITY, oERR_FRAME, oERR_TIMEOUT, oOVERRUN;
  logic [7:0] oDATA;

  gci_std_kmc_ps2_rx #(.P_TIMEOUT(TMO), .P_FILTER(FLT)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC),
    .iPS2_CLK(iPS2_CLK), .iPS2_DATA(iPS2_DATA),
    .oDATA_VALID(oDATA_VALID), .oDATA(oDATA), .iDATA_READY(iDATA_READY),
    .oERR_PARITY(oERR_PARITY), .oERR_FRAME(oERR_FRAME),
    .oERR_TIMEOUT(oERR_TIMEOUT), .oOVERRUN(oOVERRUN)
  );

  always #5 iCLOCK = ~iCLOCK;

`ifdef GCI_STD_KMC_PS2_RX_FILTER_EN
  localparam int EDGE_LAT = FLT;
  localparam int GLITCH_TMO = 0;
`else
  localparam int EDGE_LAT = 0;
  localparam int GLITCH_TMO = 1;
`endif

  int checks = 0, failures = 0;
  int cyc = 0, last_fall = 0, tmo_cyc = 0;
  int n_par = 0, n_frm = 0, n_tmo = 0, n_ovr = 0;

  always @(posedge iCLOCK) cyc <= cyc + 1;

  always @(negedge iCLOCK) begin
    if (oERR_PARITY)  n_par++;
    if (oERR_FRAME)   n_frm++;
    if (oERR_OVERRUN_w()) n_ovr++;
    if (oERR_TIMEOUT) begin n_tmo++; tmo_cyc = cyc; end
  end

  function automatic logic oERR_OVERRUN_w();
    return oOVERRUN;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge iCLOCK); #1; end
  endtask

  task automatic send_bit(input logic d, input logic rdy);
    iPS2_DATA = d;
    step(10);
    iPS2_CLK    = 1'b0;
    last_fall   = cyc;
    iDATA_READY = rdy;
    step(1);
    iDATA_READY = 1'b0;
    step(9);
    iPS2_CLK = 1'b1;
  endtask

  // sends the first nbits of {stop, par, b, start}; ready pulses on the stop fall if rdy_stop
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input logic rdy_stop, input int nbits);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], rdy_stop && (i == 10));
    iPS2_DATA = 1'b1;
  endtask

  task automatic consume();
    iDATA_READY = 1'b1;
    step(1);
    iDATA_READY = 1'b0;
  endtask

  int p0, f0, t0, o0;

  initial begin
    step(3);
    chk("rst_valid", oDATA_VALID, 0);
    chk("rst_data",  oDATA, 0);
    chk("rst_errs",  {oERR_PARITY, oERR_FRAME, oERR_TIMEOUT, oOVERRUN}, 0);
    iRESET = 1'b0;
    step(3);

    // 0xA5, even popcount -> parity bit 1
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 11);
    chk("a5_valid", oDATA_VALID, 1);
    chk("a5_data",  oDATA, 8'hA5);
    step(30);
    chk("a5_hold_valid", oDATA_VALID, 1);
    chk("a5_hold_data",  oDATA, 8'hA5);
    consume();
    chk("a5_consumed", oDATA_VALID, 0);
    chk("a5_no_errs", n_par + n_frm + n_tmo + n_ovr, 0);

    p0 = n_par;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 11);
    chk("3c_bad_par_pulse", n_par - p0, 1);
    chk("3c_bad_no_valid",  oDATA_VALID, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 11);
    chk("3c_good_valid", oDATA_VALID, 1);
    chk("3c_good_data",  oDATA, 8'h3C);
    chk("3c_good_no_par", n_par - p0, 1);
    consume();

    p0 = n_par; f0 = n_frm;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 11);
    chk("55_frame_pulse", n_frm - f0, 1);
    chk("55_no_par",      n_par - p0, 0);
    chk("55_no_valid",    oDATA_VALID, 0);

    t0 = n_tmo;
    send_frame(8'b0000_1101, 1'b0, 1'b0, 1'b0, 5);
    step(100);
    chk("tmo_pulse",   n_tmo - t0, 1);
    chk("tmo_latency", tmo_cyc - last_fall, 65 + EDGE_LAT);
    chk("tmo_no_valid", oDATA_VALID, 0);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0, 11);
    chk("12_valid", oDATA_VALID, 1);
    chk("12_data",  oDATA, 8'h12);
    chk("12_no_more_tmo", n_tmo - t0, 1);
    consume();

    // 0x01 and 0x02 have odd popcount -> parity bit 0
    o0 = n_ovr;
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, 11);
    send_frame(8'h02, 1'b0, 1'b1, 1'b0, 11);
    chk("ovr_pulse", n_ovr - o0, 1);
    chk("ovr_data",  oDATA, 8'h01);
    chk("ovr_valid", oDATA_VALID, 1);
`ifdef GCI_STD_KMC_PS2_RX_FILTER_EN
    // stop fall reaches the FSM FLT cycles after the line drops
    send_frame(8'h02, 1'b0, 1'b1, 1'b0, 10);
    iPS2_DATA = 1'b1; step(10);
    iPS2_CLK = 1'b0; step(FLT - 1);
    iDATA_READY = 1'b1; step(1); iDATA_READY = 1'b0;
    step(10 - FLT); iPS2_CLK = 1'b1;
`else
    send_frame(8'h02, 1'b0, 1'b1, 1'b1, 11);
`endif
    chk("ovr2_no_pulse", n_ovr - o0, 1);
    chk("ovr2_data",  oDATA, 8'h02);
    chk("ovr2_valid", oDATA_VALID, 1);

    // sync reset mid-frame drops both the partial frame and the buffered byte
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 3);
    iRESET_SYNC = 1'b1; step(1); iRESET_SYNC = 1'b0;
    chk("srst_valid", oDATA_VALID, 0);
    chk("srst_data",  oDATA, 0);
    step(5);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 11);
    chk("81_valid", oDATA_VALID, 1);
    chk("81_data",  oDATA, 8'h81);
    consume();

    t0 = n_tmo;
    iPS2_DATA = 1'b0; step(5);
    iPS2_CLK = 1'b0; step(3);
    iPS2_CLK = 1'b1; step(100);
    iPS2_DATA = 1'b1;
    chk("glitch_tmo", n_tmo - t0, GLITCH_TMO);
    chk("glitch_no_valid", oDATA_VALID, 0);
    chk("final_no_stray_errs", n_par + n_frm, 1 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/gci_std_kmc_ps2_rx.md
Name: gci_std_kmc_ps2_rx

Overview:
PS/2 receive deserializer that sits directly downstream of the keyboard/mouse 2-flop synchronizer. It consumes the synchronized PS/2 clock and data lines and detects falling edges of the PS/2 clock. It assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop) and presents each good byte on a one-entry valid/ready output buffer. Parity, framing, timeout and overrun conditions are reported as single-cycle error pulses.

Parameters:
P_TIMEOUT, 100000, cycles allowed between PS/2 clock falling edges inside a frame before abort (2 ms at 50 MHz); counter width clog2(P_TIMEOUT+1).
P_FILTER, 8, consecutive stable samples required by the clock glitch filter (used only with the optional feature).

Ports:
iCLOCK  input  1  system clock
iRESET  input  1  asynchronous reset, active-high
iRESET_SYNC  input  1  synchronous reset, active-high; same effect as iRESET but takes effect at the clock edge
iPS2_CLK  input  1  synchronized PS/2 clock line (idle high)
iPS2_DATA  input  1  synchronized PS/2 data line (idle high)
oDATA_VALID  output  1  oDATA holds an unread byte
oDATA  output  8  received byte
iDATA_READY  input  1  consumer accepts the byte when oDATA_VALID=1
oERR_PARITY  output  1  one-cycle pulse: parity check failed
oERR_FRAME  output  1  one-cycle pulse: stop bit was 0
oERR_TIMEOUT  output  1  one-cycle pulse: frame aborted by timeout
oOVERRUN  output  1  one-cycle pulse: good byte dropped because the buffer was full

Behaviour:
- Reset (iRESET or iRESET_SYNC) values:
  - All outputs 0.
  - FSM in IDLE.
  - Previous-clock register = 1; filtered clock = 1.
  - Shift register and bit counter = 0; timeout counter = 0.
- Edge detect:
  - fall = prev_clk & ~clk, where clk is iPS2_CLK (or the filtered clock when the feature is on).
  - prev_clk <= clk every cycle.
  - iPS2_DATA is sampled in the same cycle that fall is asserted.
- FSM, advancing only on fall:
  - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay in IDLE (spurious edge ignored).
  - DATA: shift the sample in LSB-first (shreg <= {data, shreg[7:1]}); after the 8th bit -> PARITY.
  - PARITY: store the parity-good flag = ^shreg ^ data (must equal 1, odd parity) -> STOP.
  - STOP: go to IDLE.
    - data=0 -> oERR_FRAME pulse; oERR_PARITY is not pulsed.
    - data=1 and parity bad -> oERR_PARITY pulse.
    - data=1 and parity good -> deliver the byte.
- Deliver:
  - If oDATA_VALID=0, or oDATA_VALID&iDATA_READY in the same cycle: oDATA <= shreg and oDATA_VALID <= 1 on the next edge.
  - Otherwise: oOVERRUN pulse, the byte is dropped, and oDATA/oDATA_VALID are unchanged.
- Latency: oDATA_VALID rises on the clock edge ending the cycle in which the stop-bit fall is detected; errors pulse with the same timing.
- Output handshake:
  - oDATA_VALID clears on a cycle with iDATA_READY=1.
  - oDATA is stable while oDATA_VALID=1.
  - iDATA_READY with oDATA_VALID=0 has no effect.
- Timeout:
  - In any state other than IDLE, the counter increments every cycle and clears on fall.
  - When it reaches P_TIMEOUT: oERR_TIMEOUT pulse, FSM -> IDLE, counter cleared.
  - A partial byte is never delivered.
  - In IDLE the counter is held at 0.
- Simultaneous fall and timeout in the same cycle: fall wins and the counter clears.
- Reset mid-frame discards the partial frame and any buffered byte.

Optional Feature:
Macro GCI_STD_KMC_PS2_RX_FILTER_EN.
- Defined:
  - The clock used by the edge detector is a filtered copy of iPS2_CLK.
  - The filtered copy takes the new value only after iPS2_CLK has differed from it for P_FILTER consecutive cycles; any return to the current value restarts the run count.
  - Adds P_FILTER cycles of edge latency.
- Undefined: iPS2_CLK feeds the edge detector directly, P_FILTER is ignored, and no filter logic exists.

Test Plan:
- Valid byte: P_TIMEOUT=64; frame 0xA5 (start 0; data 1,0,1,0,0,1,0,1; parity 1; stop 1) at 20 cycles per bit, iDATA_READY=0 -> oDATA=0xA5, oDATA_VALID=1 and held; then iDATA_READY=1 for one cycle -> oDATA_VALID=0; no error pulses.
- Parity error: frame 0x3C with parity bit 0 -> exactly one oERR_PARITY pulse, oDATA_VALID stays 0; a following good 0x3C frame (parity 1) is delivered.
- Framing error: frame 0x55 with stop bit 0 -> one oERR_FRAME pulse, no oERR_PARITY, no delivery.
- Timeout: P_TIMEOUT=64; start bit plus 4 data bits, then clock held high for 100 cycles -> one oERR_TIMEOUT pulse 64 cycles after the last fall; a next full frame 0x12 is delivered correctly.
- Overrun: two frames 0x01 then 0x02 with iDATA_READY=0 -> oOVERRUN pulse at the second stop bit, oDATA stays 0x01. Repeat with iDATA_READY=1 on the delivery cycle of the second frame -> oDATA=0x02, no overrun.
- Filter: iPS2_DATA=0, 3-cycle low glitch on iPS2_CLK, P_FILTER=8. With GCI_STD_KMC_PS2_RX_FILTER_EN the FSM stays IDLE and a later timeout does not fire; without the macro the FSM enters DATA and oERR_TIMEOUT pulses after P_TIMEOUT cycles.
